// File: rtl/rr_delay_scheduler_pkg.sv
// Shared definitions for the round-robin delay scheduler: sequencer state
// encoding and the power-on delay value.
package rr_sched_pkg;

    localparam int STATE_W       = 2;
    localparam int DEFAULT_DELAY = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/rr_delay_scheduler_if.sv
// Requester-side bus of the delay scheduler: level requests, delay config,
// and the owner/completion indications returned by the scheduler.
interface rr_delay_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req;
    logic               cfg_we;
    logic [CNT_W-1:0]   cfg_delay;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic [NUM_REQ-1:0] done;
    logic               abort;

    modport master (
        output req, cfg_we, cfg_delay,
        input  grant, grant_id, busy, done, abort
    );

    modport slave (
        input  req, cfg_we, cfg_delay,
        output grant, grant_id, busy, done, abort
    );
endinterface

// File: rtl/rr_delay_scheduler_pick.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               valid,
    output logic [ID_W-1:0]    winner
);
    logic [ID_W-1:0]    idx [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // idx[gi] is the requester examined at search position gi
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [ID_W:0] sum;
        assign sum     = {1'b0, rr_ptr} + (ID_W+1)'(gi);
        assign idx[gi] = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                    : ID_W'(sum);
        assign hit[gi] = req[idx[gi]];
    end

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid  = 1'b1;
                winner = idx[k];
            end
        end
    end
endmodule

// File: rtl/rr_delay_scheduler.sv
// Shares one programmable wait timer between NUM_REQ requesters using
// round-robin arbitration; each job runs delay+1 WAIT cycles then pulses done.
module rr_delay_scheduler
    import rr_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input logic                 clk,
    input logic                 rst,
    rr_delay_scheduler_if.slave bus
);
    state_t             state_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [ID_W-1:0]    grant_id_reg;
    logic               busy_reg;
    logic [NUM_REQ-1:0] done_reg;
    logic               abort_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   delay_cfg_reg;
    logic [CNT_W-1:0]   delay_q_reg;
    logic [ID_W-1:0]    rr_ptr_reg;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_reg),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    // The owner just served drops to lowest priority for the next pick
    assign ptr_next = (grant_id_reg == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            grant_id_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= '0;
            abort_reg     <= 1'b0;
            count_reg     <= '0;
            delay_cfg_reg <= CNT_W'(DEFAULT_DELAY);
            delay_q_reg   <= CNT_W'(DEFAULT_DELAY);
            rr_ptr_reg    <= '0;
        end else begin
            if (bus.cfg_we) begin
                delay_cfg_reg <= bus.cfg_delay;
            end
            done_reg  <= '0;
            abort_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        state_reg    <= WAIT;
                        grant_reg    <= NUM_REQ'(1) << pick_id;
                        grant_id_reg <= pick_id;
                        busy_reg     <= 1'b1;
                        delay_q_reg  <= delay_cfg_reg;
                        count_reg    <= '0;
                    end
                end
                WAIT: begin
                    // Owner withdrawing its request wins over a same-cycle completion
                    if (!bus.req[grant_id_reg]) begin
                        state_reg    <= IDLE;
                        grant_reg    <= '0;
                        grant_id_reg <= '0;
                        busy_reg     <= 1'b0;
                        abort_reg    <= 1'b1;
                        count_reg    <= '0;
                        rr_ptr_reg   <= ptr_next;
                    end else if (count_reg == delay_q_reg) begin
                        state_reg <= DONE;
                        done_reg  <= grant_reg;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg    <= IDLE;
                    grant_reg    <= '0;
                    grant_id_reg <= '0;
                    busy_reg     <= 1'b0;
                    rr_ptr_reg   <= ptr_next;
                end
                default: begin
                    state_reg    <= IDLE;
                    grant_reg    <= '0;
                    grant_id_reg <= '0;
                    busy_reg     <= 1'b0;
                    count_reg    <= '0;
                end
            endcase
        end
    end

    assign bus.grant    = grant_reg;
    assign bus.grant_id = grant_id_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.abort    = abort_reg;
endmodule

// File: tb/tb_rr_delay_scheduler.sv
// Directed self-checking bench for rr_delay_scheduler (NUM_REQ=4, CNT_W=4).
module tb_rr_delay_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rr_delay_scheduler_if #(.NUM_REQ(4), .CNT_W(4)) bus ();

    rr_delay_scheduler #(
        .NUM_REQ (4),
        .CNT_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done or abort shows; cycles = ticks taken, -1 on timeout
    task automatic wait_done(input string tag, output int cycles, output logic [3:0] d);
        cycles = -1;
        d      = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.done != 0 || bus.abort) begin
                cycles = i;
                d      = bus.done;
                break;
            end
        end
        $display("%s: done=%b abort=%0b cycles=%0d", tag, d, bus.abort, cycles);
    endtask

    task automatic write_cfg(input logic [3:0] v);
        bus.cfg_we    = 1'b1;
        bus.cfg_delay = v;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    initial begin
        int         cyc;
        logic [3:0] d;

        bus.req       = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_delay = '0;
        rst           = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst_grant", bus.grant, 0);
        check_val("rst_id", bus.grant_id, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_abort", bus.abort, 0);

        // Single job with default delay 4
        bus.req = 4'b0001;
        tick();
        check_val("t1_grant", bus.grant, 4'b0001);
        check_val("t1_busy", bus.busy, 1);
        wait_done("t1_job", cyc, d);
        check_val("t1_cycles", cyc, 5);
        check_val("t1_done", d, 4'b0001);
        bus.req = '0;
        tick();
        check_val("t1_idle_busy", bus.busy, 0);
        check_val("t1_idle_grant", bus.grant, 0);
        check_val("t1_idle_done", bus.done, 0);

        // Delay 0: one WAIT cycle then DONE
        write_cfg(4'd0);
        bus.req = 4'b0100;
        tick();
        check_val("t2_id", bus.grant_id, 2);
        wait_done("t2_job", cyc, d);
        check_val("t2_cycles", cyc, 1);
        check_val("t2_done", d, 4'b0100);
        bus.req = '0;
        tick();

        // Delay 15: 16 WAIT cycles, counter must not wrap
        write_cfg(4'd15);
        bus.req = 4'b0100;
        wait_done("t3_job", cyc, d);
        check_val("t3_cycles", cyc, 17);
        check_val("t3_done", d, 4'b0100);
        bus.req = '0;
        tick();

        // Config change mid-job: current job keeps 4, next uses 2
        write_cfg(4'd4);
        bus.req = 4'b0001;
        tick();
        tick();
        write_cfg(4'd2);
        wait_done("t4_job_a", cyc, d);
        check_val("t4a_cycles", cyc, 3);
        check_val("t4a_done", d, 4'b0001);
        wait_done("t4_job_b", cyc, d);
        check_val("t4b_cycles", cyc, 5);
        check_val("t4b_done", d, 4'b0001);
        bus.req = '0;
        tick();

        // Fairness: all requesting, order 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            logic [3:0] exp_d;
            exp_d = 4'b0001 << (j % 4);
            wait_done("t5_job", cyc, d);
            check_val("t5_cycles", cyc, (j == 0) ? 6 : 7);
            check_val("t5_done", d, exp_d);
        end
        bus.req = '0;
        tick();

        // Abort: owner 1 drops on its 2nd WAIT cycle, 3 then served
        bus.req = 4'b1010;
        tick();
        check_val("t6_grant", bus.grant, 4'b0010);
        tick();
        bus.req = 4'b1000;
        tick();
        check_val("t6_abort", bus.abort, 1);
        check_val("t6_ab_done", bus.done, 0);
        check_val("t6_ab_grant", bus.grant, 0);
        tick();
        check_val("t6_abort_end", bus.abort, 0);
        check_val("t6_next_grant", bus.grant, 4'b1000);
        wait_done("t6_job", cyc, d);
        check_val("t6_cycles", cyc, 5);
        check_val("t6_done", d, 4'b1000);
        bus.req = '0;
        tick();

        // Reset mid-WAIT; cfg written on the grant edge must not affect this job
        bus.req       = 4'b0100;
        bus.cfg_we    = 1'b1;
        bus.cfg_delay = 4'd1;
        tick();
        bus.cfg_we = 1'b0;
        check_val("t7_grant", bus.grant, 4'b0100);
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        bus.req = 4'b1010;
        check_val("t7_rst_grant", bus.grant, 0);
        check_val("t7_rst_busy", bus.busy, 0);
        check_val("t7_rst_done", bus.done, 0);
        check_val("t7_rst_abort", bus.abort, 0);
        tick();
        check_val("t7_grant_after", bus.grant, 4'b0010);
        check_val("t7_id_after", bus.grant_id, 1);
        wait_done("t7_job", cyc, d);
        check_val("t7_cycles", cyc, 5);
        check_val("t7_done", d, 4'b0010);
        bus.req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
